// File: rtl/kvaz_pkg.sv
// Shared types and constants for the kvaz RAM-disk SDRAM bridge.
package kvaz_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DONE
    } state_e;

    localparam int SDRAM_AW = 19;
    localparam int PAGE_W   = 3;

    localparam logic [7:0] RDATA_DEFAULT = 8'hFF;

    // Watchdog counter width: wide enough for the limit, never narrower than 8 bits.
    function automatic int unsigned wd_width(input int unsigned cycles);
        int unsigned w;
        w = $clog2(cycles + 1);
        return (w < 8) ? 8 : w;
    endfunction

endpackage

// File: rtl/kvaz_sdram_bridge_if.sv
// SDRAM controller request port: level req held until a one-cycle ack.
interface kvaz_sdram_bridge_if;
    import kvaz_pkg::*;

    logic                sdram_req;
    logic                sdram_we;
    logic [SDRAM_AW-1:0] sdram_addr;
    logic [7:0]          sdram_wdata;
    logic                sdram_ack;
    logic [7:0]          sdram_rdata;

    modport master (
        output sdram_req, sdram_we, sdram_addr, sdram_wdata,
        input  sdram_ack, sdram_rdata
    );

    modport slave (
        input  sdram_req, sdram_we, sdram_addr, sdram_wdata,
        output sdram_ack, sdram_rdata
    );

endinterface

// File: rtl/kvaz_bridge_watchdog.sv
// REQ-state watchdog: counts cycles while run is high, flags the last allowed cycle.
// Only built with KVAZ_BRIDGE_TIMEOUT_EN defined.
`ifdef KVAZ_BRIDGE_TIMEOUT_EN
module kvaz_bridge_watchdog
    import kvaz_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic expired
);
    localparam int CNT_W = int'(wd_width(TIMEOUT_CYCLES));

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Clearing whenever run is low means every REQ entry starts from zero.
    always_comb begin
        cnt_d = run ? cnt_q + 1'b1 : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign expired = run && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/kvaz_sdram_bridge.sv
// kvaz_sdram_bridge: turns one mapped CPU memory cycle into one SDRAM byte request.
// Optional KVAZ_BRIDGE_TIMEOUT_EN adds a watchdog that aborts a stalled request.
module kvaz_sdram_bridge
    import kvaz_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clke,
    input  logic [15:0]       address,
    input  logic [PAGE_W-1:0] bigram_addr,
    input  logic              blk_n,
    input  logic              memrd,
    input  logic              memwr,
    input  logic [7:0]        cpu_dout,
    output logic [7:0]        cpu_din,
    output logic              ready,
    output logic              kvaz_access,
    output logic              timeout_err,
    kvaz_sdram_bridge_if.master sdram
);
    state_e              state_q, state_d;
    logic [SDRAM_AW-1:0] addr_q, addr_d;
    logic                we_q, we_d;
    logic [7:0]          wdata_q, wdata_d;
    logic [7:0]          din_q, din_d;
    logic                kvaz_q, kvaz_d;
    logic                terr_q, terr_d;
    logic                expired;

`ifdef KVAZ_BRIDGE_TIMEOUT_EN
    kvaz_bridge_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .run    (state_q == ST_REQ),
        .expired(expired)
    );
`else
    assign expired = 1'b0;
`endif

    always_comb begin
        // NOTE: every _d takes its hold value first so no path leaves a latch behind.
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        din_d   = din_q;
        kvaz_d  = kvaz_q;
        terr_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clke && (memrd || memwr)) begin
                    addr_d  = {bigram_addr, address};
                    we_d    = memwr;
                    wdata_d = cpu_dout;
                    kvaz_d  = ~blk_n;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // A simultaneous ack beats the watchdog.
                if (sdram.sdram_ack) begin
                    if (!we_q) din_d = sdram.sdram_rdata;
                    state_d = ST_DONE;
                end else if (expired) begin
                    if (!we_q) din_d = RDATA_DEFAULT;
                    terr_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Wait for the CPU strobe to end so one strobe yields one request.
                if (clke && !memrd && !memwr) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments; reset is synchronous to clk.
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            din_q   <= RDATA_DEFAULT;
            kvaz_q  <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            din_q   <= din_d;
            kvaz_q  <= kvaz_d;
            terr_q  <= terr_d;
        end
    end

    assign sdram.sdram_req   = (state_q == ST_REQ);
    assign sdram.sdram_we    = we_q;
    assign sdram.sdram_addr  = addr_q;
    assign sdram.sdram_wdata = wdata_q;
    assign ready             = (state_q != ST_REQ);
    assign cpu_din           = din_q;
    assign kvaz_access       = kvaz_q;
    assign timeout_err       = terr_q;

endmodule
